sel_enc: RTL and testbench
==========================

SEL_ENC -- requirements
Module: sel_enc

Interface
REQ-001 Parameter CNT_W, default 8, sets the width of the error counter.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sel_in  input  32  active-low select vector to be encoded.
REQ-005 in_valid  input  1  sel_in is valid this cycle.
REQ-006 in_ready  output  1  block accepts sel_in this cycle.
REQ-007 addr_out  output  5  encoded address.
REQ-008 idle_out  output  1  result was the all-ones (no select) vector.
REQ-009 err_out  output  1  result was a non-code vector.
REQ-010 out_valid  output  1  addr_out, idle_out and err_out are valid.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 err_clr  input  1  synchronous clear of err_cnt.
REQ-013 err_cnt  output  CNT_W  saturating count of error results.

Function
REQ-014 The code table SHALL be:
- addr 0 = 0xFFFFFFFE.
- addr 1..5 = bit addr low plus bit 6 low (0xFFFFFFBD, BB, B7, AF, 9F).
- addr 7..23 = only bit addr low.
- addr 6 and addr 24..31 have no code word.
REQ-015 An exact match to a table entry SHALL give addr_out = that address, idle_out = 0, err_out = 0.
REQ-016 0xFFFFFFFF SHALL give idle_out = 1, err_out = 0, addr_out = 0.
REQ-017 Any other vector SHALL give err_out = 1, idle_out = 0, addr_out = 31. Examples: 0xFFFFFFBF (bit 6 only), 0xFFFFFFBE, and two or more low bits outside the bit-6 pairs.
REQ-018 Pipeline: two register stages.
- Stage A captures sel_in.
- Stage B holds the encoded result and drives the outputs.
REQ-019 Both stages SHALL advance together when adv = !out_valid | out_ready. in_ready SHALL equal adv.
REQ-020 A transfer is in_valid & in_ready. A transfer in cycle N SHALL appear with out_valid = 1 at cycle N+2 when out_ready stays high.
REQ-021 Stage valids follow the transfers:
- When adv = 1 and in_valid = 0, a bubble SHALL enter stage A.
- Stage B valid SHALL load stage A valid on adv.
REQ-022 While out_valid = 1 and out_ready = 0, all of the following SHALL hold stable:
- both stages;
- addr_out, idle_out, err_out, out_valid;
- in_ready = 0.
REQ-023 With in_valid and out_ready held high, the block SHALL give one result per cycle with no bubbles.
REQ-024 Results SHALL leave in arrival order. None SHALL be dropped or duplicated.

Reset
REQ-025 rst_n low SHALL asynchronously clear:
- both stage valids and stage A data;
- addr_out = 0, idle_out = 0, err_out = 0, out_valid = 0;
- err_cnt = 0.
REQ-026 in_ready SHALL be 1 during and after reset, because out_valid = 0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight results. The first transfer after release SHALL take 2 cycles again.

Configuration
REQ-028 Macro SEL_ENC_ERRCNT_EN compiles in the error counter:
- Enabled: err_cnt SHALL increment by 1 each time an err_out = 1 result loads into stage B.
- Enabled: err_cnt SHALL saturate at 2^CNT_W-1.
- Enabled: err_clr SHALL set it to 0 on the next edge; err_clr wins over a coincident increment.
- Not defined: err_cnt SHALL be constant 0, err_clr SHALL be ignored, and ports and all other behaviour SHALL be unchanged.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Reset, then sel_in = 0xFFFFFFBB, in_valid = 1 at cycle 0, out_ready = 1 -> at cycle 2: out_valid = 1, addr_out = 2, idle_out = 0, err_out = 0.
- Back-to-back 0xFFFFFFFE, 0xFF7FFFFF, 0xFFFFFFFF -> consecutive results (0, code), (23, code), (0, idle_out = 1) with no gaps.
- 0xFFFFFFBF, then 0xFFFFFF3F -> two results with err_out = 1 and addr_out = 31; with the macro, err_cnt = 2.
- out_ready = 0 for 3 cycles with two items in flight -> outputs held, in_ready = 0; after release, both results in order.
- Macro on, CNT_W = 2, five error vectors -> err_cnt = 3. Then err_clr together with a new error -> err_cnt = 0.
- rst_n low while two results are pending -> out_valid = 0 immediately and no stale result after release.

Source files
------------

// File: rtl/sel_enc.sv
// sel_enc: two-stage pipelined encoder for an active-low 32-bit select vector.
// Stage A registers the raw vector. Stage B registers the encoded address together
// with the idle and error flags, and drives the outputs. Both stages advance together
// under a single advance signal.
// Optional feature: define SEL_ENC_ERRCNT_EN to compile in the saturating error counter.
// Without it, err_cnt is tied to zero and err_clr is ignored.
module sel_enc #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      sel_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [4:0]       addr_out,
    output logic             idle_out,
    output logic             err_out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    // Bit 6 is the shared partner bit of the addresses 1..5.
    localparam int PAIR_BIT = 6;

    logic        adv;
    logic        a_valid_q;
    logic [31:0] a_sel_q;
    logic        b_valid_q;
    logic [4:0]  b_addr_q;
    logic        b_idle_q;
    logic        b_err_q;

    logic [4:0]  enc_addr_d;
    logic        enc_idle_d;
    logic        enc_err_d;

    // A stall occurs only while a valid result is held and nobody takes it.
    assign adv      = !b_valid_q || out_ready;
    assign in_ready = adv;

    // Decode the selected bits of stage A into an address, an idle flag and an error flag.
    logic [31:0] low_bits;
    logic [31:0] rest_bits;
    logic        rest_single;
    logic [4:0]  rest_idx;
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        low_bits    = ~a_sel_q;
        rest_bits   = low_bits & ~(32'h1 << PAIR_BIT);
        rest_single = (rest_bits != 32'h0) && ((rest_bits & (rest_bits - 32'h1)) == 32'h0);
        rest_idx    = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (rest_bits[i]) begin
                rest_idx = i[4:0];
            end
        end

        enc_addr_d = 5'd31;
        enc_idle_d = 1'b0;
        enc_err_d  = 1'b1;
        if (low_bits == 32'h0) begin
            enc_addr_d = 5'd0;
            enc_idle_d = 1'b1;
            enc_err_d  = 1'b0;
        end else if (rest_single && !low_bits[PAIR_BIT]) begin
            // A lone selected bit is a code only for address 0 and for addresses 7..23.
            if (rest_idx == 5'd0 || (rest_idx >= 5'd7 && rest_idx <= 5'd23)) begin
                enc_addr_d = rest_idx;
                enc_err_d  = 1'b0;
            end
        end else if (rest_single && low_bits[PAIR_BIT]) begin
            // A selected bit paired with bit 6 is a code only for addresses 1..5.
            if (rest_idx >= 5'd1 && rest_idx <= 5'd5) begin
                enc_addr_d = rest_idx;
                enc_err_d  = 1'b0;
            end
        end
    end

    // Stage A captures the input vector. A cycle without in_valid inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q <= 1'b0;
            a_sel_q   <= 32'h0;
        end else if (adv) begin
            // NOTE: sequential state uses non-blocking assignments, so both stages read pre-edge values.
            a_valid_q <= in_valid;
            a_sel_q   <= sel_in;
        end
    end

    // Stage B loads the encoded result of stage A and holds it while it is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid_q <= 1'b0;
            b_addr_q  <= 5'd0;
            b_idle_q  <= 1'b0;
            b_err_q   <= 1'b0;
        end else if (adv) begin
            b_valid_q <= a_valid_q;
            b_addr_q  <= enc_addr_d;
            b_idle_q  <= enc_idle_d;
            b_err_q   <= enc_err_d;
        end
    end

    assign out_valid = b_valid_q;
    assign addr_out  = b_addr_q;
    assign idle_out  = b_idle_q;
    assign err_out   = b_err_q;

`ifdef SEL_ENC_ERRCNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count each error result as it enters stage B. Saturate at all-ones. A clear wins.
    always_comb begin
        cnt_d = cnt_q;
        if (err_clr) begin
            cnt_d = '0;
        end else if (adv && a_valid_q && enc_err_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_sel_enc.sv
// tb_sel_enc: scoreboard bench for sel_enc. The driver pushes the expected result
// of every accepted vector into a queue. An independent monitor pops an entry and
// compares it each time the DUT hands a result downstream.
module tb_sel_enc;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [31:0]      sel_in = 32'hFFFF_FFFF;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [4:0]       addr_out;
    logic             idle_out;
    logic             err_out;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    sel_enc #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel_in    (sel_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .addr_out  (addr_out),
        .idle_out  (idle_out),
        .err_out   (err_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .err_cnt   (err_cnt)
    );

    typedef struct packed {
        logic [4:0] addr;
        logic       idle;
        logic       err;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Table code word of an address. has=0 means the address has no code word.
    function automatic logic [31:0] code_of(input int a, output bit has);
        has = 1'b1;
        if (a == 0)                 return ~32'h1;
        else if (a >= 1 && a <= 5)  return ~((32'h1 << a) | (32'h1 << 6));
        else if (a >= 7 && a <= 23) return ~(32'h1 << a);
        has = 1'b0;
        return 32'h0;
    endfunction

    // Reference model: look the vector up in the code table.
    function automatic res_t ref_model(input logic [31:0] v);
        res_t r;
        bit   has;
        logic [31:0] w;
        r.addr = 5'd31; r.idle = 1'b0; r.err = 1'b1;
        if (v == 32'hFFFF_FFFF) begin
            r.addr = 5'd0; r.idle = 1'b1; r.err = 1'b0;
            return r;
        end
        for (int a = 0; a < 32; a++) begin
            w = code_of(a, has);
            if (has && v == w) begin
                r.addr = a[4:0]; r.idle = 1'b0; r.err = 1'b0;
            end
        end
        return r;
    endfunction

    // Driver side of the scoreboard: record each accepted vector's expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            res_t r;
            r = ref_model(sel_in);
            exp_q.push_back(r);
            if (r.err && model_cnt < CNT_MAX) model_cnt++;
        end
    end

    // Monitor: handshake rule, stall stability, and in-order result comparison.
    bit   prev_stall = 1'b0;
    res_t held;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (prev_stall) begin
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({addr_out, idle_out, err_out}), 32'(held));
            end
            prev_stall = out_valid && !out_ready;
            held       = '{addr: addr_out, idle: idle_out, err: err_out};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'({addr_out, idle_out, err_out}), 32'hDEAD);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check("result_addr", 32'(addr_out), 32'(e.addr));
                    check("result_idle", 32'(idle_out), 32'(e.idle));
                    check("result_err",  32'(err_out),  32'(e.err));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_outputs",   32'({addr_out, idle_out, err_out}), 32'd0);
        check("rst_err_cnt",   32'(err_cnt),   32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one vector and hold it until it is accepted. Returns 1 ns after the accepting edge.
    task automatic send(input logic [31:0] v);
        int n = 0;
        sel_in   = v;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL send_timeout actual=no_accept expected=accept vector=%0h", v);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_left expected=0_left", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name);
`ifdef SEL_ENC_ERRCNT_EN
        check(name, 32'(err_cnt), 32'(model_cnt));
`else
        check(name, 32'(err_cnt), 32'd0);
`endif
    endtask

    // A transfer must appear exactly two cycles later with the reference result.
    task automatic latency_check(input string name, input logic [31:0] v);
        res_t e;
        e = ref_model(v);
        out_ready = 1'b1;
        send(v);
        @(negedge clk);
        check({name, "_n1_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_n2_valid"}, 32'(out_valid), 32'd1);
        check({name, "_n2_result"}, 32'({addr_out, idle_out, err_out}), 32'(e));
    endtask

    function automatic logic [31:0] rand_vec();
        bit has;
        int a;
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0: begin
                do begin
                    a = $urandom_range(0, 31);
                    v = code_of(a, has);
                end while (!has);
                return v;
            end
            1: return 32'hFFFF_FFFF;
            2: return ~(32'h1 << $urandom_range(0, 31));
            3: return ~((32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31)));
            default: return $urandom();
        endcase
    endfunction

    bit rand_done;

    initial begin
        #3;
        do_reset();

        // First result, and its latency after reset.
        latency_check("first", 32'hFFFF_FFBB);
        drain();

        // Back-to-back vectors with no gaps.
        send(32'hFFFF_FFFE);
        send(32'hFF7F_FFFF);
        send(32'hFFFF_FFFF);
        @(negedge clk);
        check("b2b_valid_2", 32'(out_valid), 32'd1);
        @(negedge clk);
        check("b2b_valid_3", 32'(out_valid), 32'd1);
        drain();

        // Two error vectors, then the counter.
        do_reset();
        send(32'hFFFF_FFBF);
        send(32'hFFFF_FF3F);
        drain();
        check_cnt("err_cnt_two");

        // Stall with two items in flight.
        send(32'hFFFF_FFDF);
        send(32'hFFFF_FF9F);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        drain();

        // Saturation with five error vectors, then a clear that coincides with a new error.
        do_reset();
        for (int i = 0; i < 5; i++) send(32'hFFFF_FFBE);
        drain();
        check_cnt("err_cnt_sat");
        send(32'h0000_0000);
        err_clr   = 1'b1;
        model_cnt = 0;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        drain();
        check_cnt("err_cnt_clr");

        // Reset while two results are pending.
        send(32'hFFFF_FFFE);
        send(32'hFFFF_FFAF);
        out_ready = 1'b0;
        @(negedge clk);
        do_reset();
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_no_stale", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        latency_check("after_rst", 32'hFFFE_FFFF);
        drain();

        // Randomized traffic with random back-pressure.
        do_reset();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rand_vec());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        check_cnt("err_cnt_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
